// File: rtl/fft_frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_frame_pkg: types and defaults shared by the window / frame / FFT chain |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fft_frame_pkg;

  localparam int unsigned FRAME_LEN_DEFAULT  = 4096;
  localparam int unsigned DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  typedef enum logic [0:0] {
    WR_FILL  = 1'b0,
    WR_STALL = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_frame_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_frame_buffer_if: sample input and AXI-stream style frame output        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fft_frame_buffer_if
  import fft_frame_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);
  logic [DATA_WIDTH-1:0] in_sample;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] out_tdata;
  logic                  out_tvalid;
  logic                  out_tready;
  logic                  out_tlast;
  logic                  overrun;

  // master: the environment (window stage + FFT); slave: the frame buffer
  modport master (
    output in_sample, in_valid, out_tready,
    input  out_tdata, out_tvalid, out_tlast, overrun
  );

  modport slave (
    input  in_sample, in_valid, out_tready,
    output out_tdata, out_tvalid, out_tlast, overrun
  );
endinterface
`default_nettype wire

// File: rtl/frame_bank_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_bank_ram: simple dual-port RAM, one write port, registered read port |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module frame_bank_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  wire logic                  clk_in,
  input  wire logic                  wr_en,
  input  wire logic [ADDR_WIDTH-1:0] wr_addr,
  input  wire logic [DATA_WIDTH-1:0] wr_data,
  input  wire logic                  rd_en,
  input  wire logic [ADDR_WIDTH-1:0] rd_addr,
  output logic      [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // No reset on the read register so the array maps onto block RAM
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_frame_buffer: ping-pong frame collector feeding the FFT as a stream    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fft_frame_buffer
  import fft_frame_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int FRAME_LEN  = FRAME_LEN_DEFAULT
) (
  input wire logic          clk_in,
  input wire logic          rst_in,
  fft_frame_buffer_if.slave bus
);

  localparam int              IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  bank_state_t      bank_state_q [2];
  bank_state_t      bank_state_d [2];
  wr_state_t        wr_state_q, wr_state_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  rd_state_t        rd_state_q, rd_state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             older_q, older_d;
  logic             out_tvalid_q, out_tvalid_d;
  logic             out_tlast_q, out_tlast_d;
  logic             overrun_q, overrun_d;

  logic             full0, full1, sel_bank;
  logic             rd_issue, release_en;
  logic             rd_addr_bank;
  logic [IDX_W-1:0] rd_addr_idx;
  logic             other_bank, other_avail, tgt_avail, wr_en;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      bank_state_q[0] <= BANK_FILLING;
      bank_state_q[1] <= BANK_FREE;
      wr_state_q      <= WR_FILL;
      wr_bank_q       <= 1'b0;
      wr_idx_q        <= '0;
      rd_state_q      <= RD_IDLE;
      rd_bank_q       <= 1'b0;
      rd_idx_q        <= '0;
      older_q         <= 1'b0;
      out_tvalid_q    <= 1'b0;
      out_tlast_q     <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      bank_state_q <= bank_state_d;
      wr_state_q   <= wr_state_d;
      wr_bank_q    <= wr_bank_d;
      wr_idx_q     <= wr_idx_d;
      rd_state_q   <= rd_state_d;
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      older_q      <= older_d;
      out_tvalid_q <= out_tvalid_d;
      out_tlast_q  <= out_tlast_d;
      overrun_q    <= overrun_d;
    end
  end

  // Read-side outputs: which RAM read to issue and whether a bank is handed back
  always_comb begin
    full0        = (bank_state_q[0] == BANK_FULL);
    full1        = (bank_state_q[1] == BANK_FULL);
    sel_bank     = (full0 && full1) ? older_q : full1;
    rd_issue     = 1'b0;
    release_en   = 1'b0;
    rd_addr_bank = rd_bank_q;
    rd_addr_idx  = rd_idx_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (full0 || full1) begin
          rd_issue     = 1'b1;
          rd_addr_bank = sel_bank;
          rd_addr_idx  = '0;
        end
      end
      RD_STREAM: begin
        release_en = out_tvalid_q && out_tlast_q && bus.out_tready;
        rd_issue   = (!out_tvalid_q || bus.out_tready) && !(out_tvalid_q && out_tlast_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_idx_d   = rd_idx_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_issue) begin
          rd_state_d = RD_STREAM;
          rd_bank_d  = sel_bank;
          rd_idx_d   = IDX_W'(1);
        end
      end
      RD_STREAM: begin
        if (release_en) begin
          rd_state_d = RD_IDLE;
        end
        if (rd_issue) begin
          rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  // The output register refills on every issued read and empties on an unrefilled accept
  always_comb begin
    out_tvalid_d = out_tvalid_q;
    out_tlast_d  = out_tlast_q;
    if (rd_issue) begin
      out_tvalid_d = 1'b1;
      out_tlast_d  = (rd_addr_idx == LAST_IDX);
    end else if (bus.out_tready) begin
      out_tvalid_d = 1'b0;
      out_tlast_d  = 1'b0;
    end
  end

  // In STALL, wr_bank_q already names the bank waiting to be refilled
  always_comb begin
    other_bank  = ~wr_bank_q;
    other_avail = (bank_state_q[other_bank] == BANK_FREE) ||
                  (release_en && (rd_bank_q == other_bank));
    tgt_avail   = (bank_state_q[wr_bank_q] == BANK_FREE) ||
                  (release_en && (rd_bank_q == wr_bank_q));
    wr_en       = bus.in_valid && ((wr_state_q == WR_FILL) || tgt_avail);
    overrun_d   = bus.in_valid && !wr_en;
  end

  always_comb begin
    bank_state_d = bank_state_q;
    wr_state_d   = wr_state_q;
    wr_bank_d    = wr_bank_q;
    wr_idx_d     = wr_idx_q;
    older_d      = older_q;
    if (release_en) begin
      bank_state_d[rd_bank_q] = BANK_FREE;
    end
    case (wr_state_q)
      WR_FILL: begin
        if (wr_en) begin
          wr_idx_d = wr_idx_q + IDX_W'(1);
          if (wr_idx_q == LAST_IDX) begin
            bank_state_d[wr_bank_q] = BANK_FULL;
            wr_bank_d               = other_bank;
            if ((bank_state_q[other_bank] != BANK_FULL) ||
                (release_en && (rd_bank_q == other_bank))) begin
              older_d = wr_bank_q;
            end
            if (other_avail) begin
              bank_state_d[other_bank] = BANK_FILLING;
            end else begin
              wr_state_d = WR_STALL;
            end
          end
        end
      end
      WR_STALL: begin
        if (tgt_avail) begin
          bank_state_d[wr_bank_q] = BANK_FILLING;
          wr_state_d              = WR_FILL;
          wr_idx_d                = wr_idx_q + IDX_W'(wr_en);
        end
      end
      default: ;
    endcase
  end

  frame_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (IDX_W + 1)
  ) u_ram (
    .clk_in  (clk_in),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank_q, wr_idx_q}),
    .wr_data (bus.in_sample),
    .rd_en   (rd_issue),
    .rd_addr ({rd_addr_bank, rd_addr_idx}),
    .rd_data (ram_rdata)
  );

  assign bus.out_tdata  = out_tvalid_q ? ram_rdata : '0;
  assign bus.out_tvalid = out_tvalid_q;
  assign bus.out_tlast  = out_tlast_q;
  assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_frame_buffer: scoreboard bench with a frame-level reference model   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fft_frame_buffer;

  localparam int DW = 8;
  localparam int N  = 8;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  fft_frame_buffer_if #(.DATA_WIDTH(DW)) bus ();

  fft_frame_buffer #(
    .DATA_WIDTH (DW),
    .FRAME_LEN  (N)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW:0]   exp_q [$];
  logic [DW-1:0] partial [$];
  int  full_frames = 0;
  int  rd_cnt      = 0;
  bit  stalled     = 1'b0;
  bit  ovr_exp     = 1'b0;
  int  ovr_seen    = 0;
  int  last_seen   = 0;
  int  beats_seen  = 0;
  int  ready_mode  = 0;
  int  cyc         = 0;

  // Reference model: frames complete in arrival order; at most two frames held
  always @(negedge clk_in) begin : model
    if (!rst_in) begin
      exp_q.delete();
      partial.delete();
      full_frames = 0;
      rd_cnt      = 0;
      stalled     = 1'b0;
      ovr_exp     = 1'b0;
    end else begin
      total++;
      if (bus.overrun !== ovr_exp) begin
        bad++;
        $display("FAIL overrun: got %b want %b at %0t", bus.overrun, ovr_exp, $time);
      end
      if (bus.overrun === 1'b1) ovr_seen++;
      if (bus.out_tvalid === 1'b1 && bus.out_tready === 1'b1) begin
        rd_cnt++;
        if (rd_cnt == N) begin
          rd_cnt = 0;
          full_frames--;
        end
      end
      ovr_exp = 1'b0;
      if (stalled && full_frames < 2) stalled = 1'b0;
      if (bus.in_valid === 1'b1) begin
        if (stalled) begin
          ovr_exp = 1'b1;
        end else begin
          partial.push_back(bus.in_sample);
          if (partial.size() == N) begin
            for (int i = 0; i < N; i++) begin
              logic l;
              l = (i == N - 1);
              exp_q.push_back({l, partial[i]});
            end
            partial.delete();
            full_frames++;
            if (full_frames == 2) stalled = 1'b1;
          end
        end
      end
    end
  end

  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk_in) begin : monitor
    logic [DW:0] e;
    if (!rst_in) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (!(bus.out_tvalid === 1'b1 && bus.out_tdata === prev_data && bus.out_tlast === prev_last)) begin
          bad++;
          $display("FAIL hold: got v=%b d=%0d l=%b want v=1 d=%0d l=%b at %0t",
                   bus.out_tvalid, bus.out_tdata, bus.out_tlast, prev_data, prev_last, $time);
        end
      end
      if (bus.out_tvalid === 1'b1 && bus.out_tready === 1'b1) begin
        beats_seen++;
        if (bus.out_tlast === 1'b1) last_seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat: got d=%0d l=%b want nothing at %0t", bus.out_tdata, bus.out_tlast, $time);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_tlast, bus.out_tdata} !== e) begin
            bad++;
            $display("FAIL beat: got d=%0d l=%b want d=%0d l=%b at %0t",
                     bus.out_tdata, bus.out_tlast, e[DW-1:0], e[DW], $time);
          end
        end
      end
      prev_stall = (bus.out_tvalid === 1'b1) && (bus.out_tready !== 1'b1);
      prev_data  = bus.out_tdata;
      prev_last  = bus.out_tlast;
    end
  end

  function automatic logic ready_val(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 4 == 0) || (c % 4 == 3);
      2:       return 1'b0;
      default: return $urandom_range(0, 9) < 6;
    endcase
  endfunction

  task automatic step(input logic v, input logic [DW-1:0] d);
    @(posedge clk_in);
    #1;
    rst_in         = 1'b1;
    bus.in_valid   = v;
    bus.in_sample  = d;
    bus.out_tready = ready_val(ready_mode, cyc);
    cyc++;
  endtask

  task automatic reset_cycle();
    @(posedge clk_in);
    #1;
    rst_in         = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_tready = ready_val(ready_mode, cyc);
    cyc++;
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic feed(input int first, input int count);
    for (int i = 0; i < count; i++) step(1'b1, DW'(first + i));
  endtask

  task automatic drain();
    int n;
    n = 0;
    step(1'b0, '0);
    while ((exp_q.size() != 0 || bus.out_tvalid === 1'b1) && n < 300) begin
      step(1'b0, '0);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || bus.out_tvalid === 1'b1) begin
      bad++;
      $display("FAIL drain: got %0d beats pending want 0", exp_q.size());
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int base;
    int n;
    bus.in_valid   = 1'b0;
    bus.in_sample  = '0;
    bus.out_tready = 1'b0;

    // reset state
    reset_cycle();
    reset_cycle();
    step(1'b0, '0);
    @(negedge clk_in);
    check("rst tvalid", int'(bus.out_tvalid), 0);
    check("rst tlast", int'(bus.out_tlast), 0);
    check("rst overrun", int'(bus.overrun), 0);
    check("rst tdata", int'(bus.out_tdata), 0);

    // single frame: first beat two cycles after the last sample
    ready_mode = 0;
    feed(1, 8);
    step(1'b0, '0);
    @(negedge clk_in);
    check("t1 tvalid k+1", int'(bus.out_tvalid), 0);
    step(1'b0, '0);
    @(negedge clk_in);
    check("t1 tvalid k+2", int'(bus.out_tvalid), 1);
    check("t1 tdata k+2", int'(bus.out_tdata), 1);
    drain();

    // two frames back to back
    base = last_seen;
    feed(1, 16);
    drain();
    check("t2 tlast count", last_seen - base, 2);

    // stalled output with ready pattern 1,0,0,1
    ready_mode = 1;
    feed(1, 8);
    drain();
    ready_mode = 0;

    // both banks held full, overruns, then release
    ready_mode = 2;
    base = ovr_seen;
    feed(1, 20);
    repeat (3) step(1'b0, '0);
    check("t4 overrun pulses", ovr_seen - base, 4);
    check("t4 held tdata", int'(bus.out_tdata), 1);
    ready_mode = 0;
    drain();
    feed(21, 8);
    drain();

    // drain completion coincides with the writer finishing the other bank
    reset_cycle();
    step(1'b0, '0);
    base = ovr_seen;
    feed(1, 8);
    step(1'b0, '0);
    feed(9, 8);
    @(negedge clk_in);
    check("t5 tlast aligned", int'(bus.out_tvalid && bus.out_tlast), 1);
    feed(17, 8);
    drain();
    check("t5 overrun pulses", ovr_seen - base, 0);

    // reset mid-stream
    base = beats_seen;
    feed(1, 8);
    n = 0;
    while (beats_seen - base < 3 && n < 50) begin
      step(1'b0, '0);
      n++;
    end
    check("t6 beats before reset", int'(beats_seen - base >= 3), 1);
    reset_cycle();
    step(1'b0, '0);
    @(negedge clk_in);
    check("t6 tvalid after reset", int'(bus.out_tvalid), 0);
    base = last_seen;
    feed(1, 8);
    drain();
    check("t6 tlast count", last_seen - base, 1);

    // randomized traffic
    ready_mode = 3;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, DW'($urandom_range(0, 255)));
    end
    ready_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
